// File: rtl/jtpopeye_rom_arb.sv
// jtpopeye_rom_arb: round-robin SDRAM read arbiter filling one-word ROM caches, one per client channel.
// Define JTPOPEYE_ROMARB_PRIO_EN to give channel 0 fixed priority over the round-robin channels.
module jtpopeye_rom_arb #(
   parameter int CHN     = 2,
   parameter int LATENCY = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              downloading,
   input  logic              loop_rst,
   input  logic [CHN-1:0]    ch_cs,
   input  logic [CHN*22-1:0] ch_addr,
   output logic [CHN*32-1:0] ch_data,
   output logic [CHN-1:0]    ch_ok,
   output logic              sdram_re,
   output logic [21:0]       sdram_addr,
   input  logic [31:0]       data_read
);
   localparam int IW = CHN > 1 ? $clog2(CHN) : 1;
   typedef enum logic [1:0] {IDLE, WAIT, CAPTURE} state_t;
   state_t         st_q, st_d;
   logic [3:0]     cnt_q, cnt_d;
   logic [IW-1:0]  last_q, last_d, g_q, g_d, gsel, scan;
   logic [21:0]    addr_q, addr_d;
   logic           re_q, re_d, found;
   logic [CHN-1:0] valid_q, valid_d, hit, pend;
   logic [21:0]    tag_q  [CHN];
   logic [21:0]    tag_d  [CHN];
   logic [31:0]    word_q [CHN];
   logic [31:0]    word_d [CHN];

   assign sdram_re   = re_q;
   assign sdram_addr = addr_q;

   for (genvar k = 0; k < CHN; k++) begin : g_ch
      assign hit[k]              = valid_q[k] & (tag_q[k] == ch_addr[22*k +: 22]);
      assign pend[k]             = ch_cs[k] & ~hit[k];
      assign ch_ok[k]            = ch_cs[k] & hit[k] & ~downloading;
      assign ch_data[32*k +: 32] = word_q[k];
   end

   // first pending channel after the last grant, wrapping around
   always_comb begin
      found = 1'b0;
      gsel  = last_q;
      scan  = last_q;
      for (int i = 1; i <= CHN; i++) begin
         scan = IW'((int'(last_q) + i) % CHN);
         if (!found && pend[scan]) begin
            found = 1'b1;
            gsel  = scan;
         end
      end
`ifdef JTPOPEYE_ROMARB_PRIO_EN
      if (pend[0]) begin
         found = 1'b1;
         gsel  = '0;
      end
`endif
   end

   always_comb begin
      st_d    = st_q;
      cnt_d   = cnt_q;
      last_d  = last_q;
      g_d     = g_q;
      addr_d  = addr_q;
      re_d    = 1'b0;
      valid_d = valid_q;
      tag_d   = tag_q;
      word_d  = word_q;
      if (downloading || loop_rst) begin
         st_d    = IDLE;
         valid_d = '0;
      end else begin
         case (st_q)
            IDLE: if (found) begin
               st_d   = WAIT;
               cnt_d  = 4'(LATENCY - 1);
               g_d    = gsel;
               addr_d = ch_addr[22*gsel +: 22];
               re_d   = 1'b1;
`ifdef JTPOPEYE_ROMARB_PRIO_EN
               if (gsel != '0) last_d = gsel;
`else
               last_d = gsel;
`endif
            end
            WAIT: begin
               cnt_d = cnt_q - 4'd1;
               if (cnt_q == 4'd0) st_d = CAPTURE;
            end
            CAPTURE: begin
               st_d         = IDLE;
               word_d[g_q]  = data_read;
               tag_d[g_q]   = addr_q;
               valid_d[g_q] = 1'b1;
            end
            default: st_d = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         st_q    <= IDLE;
         cnt_q   <= '0;
         last_q  <= IW'(CHN - 1);
         g_q     <= '0;
         addr_q  <= '0;
         re_q    <= 1'b0;
         valid_q <= '0;
         for (int i = 0; i < CHN; i++) begin
            tag_q[i]  <= '0;
            word_q[i] <= '0;
         end
      end else begin
         st_q    <= st_d;
         cnt_q   <= cnt_d;
         last_q  <= last_d;
         g_q     <= g_d;
         addr_q  <= addr_d;
         re_q    <= re_d;
         valid_q <= valid_d;
         tag_q   <= tag_d;
         word_q  <= word_d;
      end
   end
endmodule

// File: tb/tb_jtpopeye_rom_arb.sv
// tb_jtpopeye_rom_arb: timestamp-level cache/arbiter model compared every cycle, plus directed literal checks.
module tb_jtpopeye_rom_arb;
   localparam int CHN = 3;
   localparam int LAT = 4;
   logic              clk = 1'b0, rst = 1'b1, downloading = 1'b0, loop_rst = 1'b0;
   logic [CHN-1:0]    ch_cs = '0;
   logic [CHN*22-1:0] ch_addr = '0;
   logic [CHN*32-1:0] ch_data;
   logic [CHN-1:0]    ch_ok;
   logic              sdram_re;
   logic [21:0]       sdram_addr;
   logic [31:0]       data_read = 32'hBAD0BAD0;
   int tests = 0, fails = 0;
   int n = 0, rd_n = -100;
   logic [21:0]       m_tag  [CHN];
   logic [31:0]       m_word [CHN];
   logic [CHN-1:0]    m_valid, prev_ok, e_ok, pend;
   logic [CHN*32-1:0] e_data;
   logic [21:0]       m_addr;
   int                m_last, re_n, cap_n, m_g, g;
   bit                busy;
   int                ok_rise [CHN];
   logic [21:0]       glog_a [$];
   int                glog_n [$];

   always #5 clk = ~clk;

   jtpopeye_rom_arb #(.CHN(CHN), .LATENCY(LAT)) dut (
      .clk(clk), .rst(rst), .downloading(downloading), .loop_rst(loop_rst),
      .ch_cs(ch_cs), .ch_addr(ch_addr), .ch_data(ch_data), .ch_ok(ch_ok),
      .sdram_re(sdram_re), .sdram_addr(sdram_addr), .data_read(data_read)
   );

   function automatic logic [31:0] mem(input logic [21:0] a);
      return a == 22'h10 ? 32'hDEADBEEF : {a[9:0], a} ^ 32'h5A5A_0000;
   endfunction

   task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s cyc=%0d got=%0h want=%0h", nm, n, act, exp);
      end
   endtask

   task automatic model_reset();
      m_valid = '0; m_last = CHN - 1; busy = 0; re_n = -100; cap_n = -100;
      m_addr = '0; m_g = 0; prev_ok = '0; n = 0; rd_n = -100;
      data_read = 32'hBAD0BAD0;
      for (int k = 0; k < CHN; k++) begin
         m_tag[k] = '0; m_word[k] = '0; ok_rise[k] = -1;
      end
      glog_a.delete(); glog_n.delete();
   endtask

   // SDRAM returns data only in the one cycle LAT after the strobe; the model is driven by timestamps
   always @(negedge clk) begin
      if (rst) model_reset();
      else begin
         data_read = (n == rd_n + LAT) ? mem(sdram_addr) : 32'hBAD0BAD0;
         #4;
         for (int k = 0; k < CHN; k++) begin
            e_ok[k] = ch_cs[k] & m_valid[k] & (m_tag[k] == ch_addr[22*k +: 22]) & ~downloading;
            pend[k] = ch_cs[k] & ~(m_valid[k] & (m_tag[k] == ch_addr[22*k +: 22]));
            e_data[32*k +: 32] = m_word[k];
         end
         chk("ch_ok", ch_ok, e_ok);
         chk("ch_data", ch_data, e_data);
         chk("sdram_re", sdram_re, n == re_n);
         chk("sdram_addr", sdram_addr, m_addr);
         if (sdram_re) begin
            glog_a.push_back(sdram_addr);
            glog_n.push_back(n);
            rd_n = n;
         end
         for (int k = 0; k < CHN; k++) if (ch_ok[k] && !prev_ok[k]) ok_rise[k] = n;
         prev_ok = ch_ok;
         if (downloading || loop_rst) begin
            m_valid = '0;
            busy = 0;
         end else if (busy) begin
            if (n == cap_n) begin
               m_word[m_g] = mem(m_addr);
               m_tag[m_g] = m_addr;
               m_valid[m_g] = 1'b1;
               busy = 0;
            end
         end else begin
            g = -1;
            for (int i = 1; i <= CHN; i++) if (g < 0 && pend[(m_last + i) % CHN]) g = (m_last + i) % CHN;
`ifdef JTPOPEYE_ROMARB_PRIO_EN
            if (pend[0]) g = 0;
`endif
            if (g >= 0) begin
               busy = 1; re_n = n + 1; cap_n = n + 1 + LAT;
               m_addr = ch_addr[22*g +: 22]; m_g = g;
`ifdef JTPOPEYE_ROMARB_PRIO_EN
               if (g != 0) m_last = g;
`else
               m_last = g;
`endif
            end
         end
         n++;
      end
   end

   task automatic do_reset();
      @(posedge clk); #2 rst = 1'b1; ch_cs = '0; downloading = 1'b0; loop_rst = 1'b0;
      @(posedge clk); #2;
      chk("rst_ok", ch_ok, '0);
      chk("rst_re", sdram_re, 1'b0);
      chk("rst_addr", sdram_addr, '0);
      chk("rst_data", ch_data, '0);
      @(posedge clk); #2 rst = 1'b0;
   endtask

   initial begin
      int t, r, s;
      logic [21:0] a;
      do_reset();
      // single miss, then a same-cycle hit
      @(negedge clk); ch_cs = 3'b001; ch_addr[21:0] = 22'h10; t = n;
      repeat (10) @(negedge clk); #1;
      chk("A_re_count", glog_a.size(), 1);
      chk("A_re_addr", glog_a[0], 22'h10);
      chk("A_re_cycle", glog_n[0], t + 1);
      chk("A_ok_rise", ok_rise[0], t + 6);
      chk("A_data", ch_data[31:0], 32'hDEADBEEF);
      @(negedge clk); ch_cs = 3'b000;
      @(negedge clk); ch_cs = 3'b001; #1 chk("A_hit", ch_ok[0], 1'b1);
      repeat (8) @(negedge clk); #1 chk("A_no_refetch", glog_a.size(), 1);
      // three simultaneous misses
      do_reset();
      @(negedge clk); ch_cs = 3'b111; ch_addr = {22'h300, 22'h200, 22'h100}; t = n;
      repeat (22) @(negedge clk); #1;
      chk("B_count", glog_a.size(), 3);
      for (int i = 0; i < 3; i++) begin
         chk("B_order", glog_a[i], 22'(256 * (i + 1)));
         chk("B_spacing", glog_n[i], t + 1 + 6 * i);
      end
      chk("B_ok", ch_ok, 3'b111);
      chk("B_data", ch_data, {mem(22'h300), mem(22'h200), mem(22'h100)});
      // address change while the read is in flight
      do_reset();
      @(negedge clk); ch_cs = 3'b010; ch_addr[43:22] = 22'h40; t = n;
      repeat (2) @(negedge clk); ch_addr[43:22] = 22'h41;
      repeat (4) @(negedge clk); #1 chk("C_stale_ok", ch_ok[1], 1'b0);
      repeat (8) @(negedge clk); #1;
      chk("C_count", glog_a.size(), 2);
      chk("C_first", glog_a[0], 22'h40);
      chk("C_second", glog_a[1], 22'h41);
      chk("C_second_cycle", glog_n[1], t + 7);
      chk("C_ok", ch_ok[1], 1'b1);
      chk("C_data", ch_data[63:32], mem(22'h41));
      // download aborts an in-flight read
      do_reset();
      @(negedge clk); ch_cs = 3'b001; ch_addr[21:0] = 22'h80; t = n;
      repeat (2) @(negedge clk); downloading = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk); #1 chk("D_ok_low", ch_ok, '0);
      end
      chk("D_no_re", glog_a.size(), 1);
      @(negedge clk); downloading = 1'b0; r = n;
      repeat (8) @(negedge clk); #1;
      chk("D_count", glog_a.size(), 2);
      chk("D_refetch_cycle", glog_n[1], r + 1);
      chk("D_refetch_addr", glog_a[1], 22'h80);
      chk("D_ok", ch_ok[0], 1'b1);
      chk("D_data", ch_data[31:0], mem(22'h80));
      // loop restart invalidates a valid line
      @(negedge clk); loop_rst = 1'b1; s = n; #1 chk("E_ok_before", ch_ok[0], 1'b1);
      @(negedge clk); loop_rst = 1'b0; #1 chk("E_ok_drop", ch_ok[0], 1'b0);
      repeat (8) @(negedge clk); #1;
      chk("E_count", glog_a.size(), 3);
      chk("E_refetch_cycle", glog_n[2], s + 2);
      chk("E_ok", ch_ok[0], 1'b1);
      // channels 0 and 1 missing every cycle
      do_reset();
      for (int c = 0; c < 26; c++) begin
         @(negedge clk); ch_cs = 3'b011;
         ch_addr[21:0] = 22'h1000 + 22'(c);
         ch_addr[43:22] = 22'h2000 + 22'(c);
      end
      #1 chk("F_count", glog_a.size() >= 4, 1'b1);
      for (int i = 0; i < 4; i++) begin
         a = glog_a[i];
`ifdef JTPOPEYE_ROMARB_PRIO_EN
         chk("F_prio", a[13:12], 2'd1);
`else
         chk("F_alternate", a[13:12], (i % 2 == 0) ? 2'd1 : 2'd2);
`endif
      end
      @(negedge clk); ch_cs = '0;
      repeat (4) @(negedge clk);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog cyc=%0d got=timeout want=finish", n);
      $fatal(1);
   end
endmodule
